// File: rtl/axil_rd_monitor.sv
// Passive AXI-Lite read-path monitor: AR/R stability, AR stall limit, outstanding
// tracking, response timeout, plus sticky/count/first-error capture of violations.
module axil_rd_monitor #(
  parameter int unsigned C_AXI_ADDR_WIDTH = 8,
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned MAXWAIT          = 5,
  parameter int unsigned RESP_MAXWAIT     = 16,
  parameter int unsigned MAX_OUTSTANDING  = 4,
  parameter int unsigned ERR_CNT_WIDTH    = 8
) (
  input  logic                                       AXI_ACLK,
  input  logic                                       AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                AXI_ARADDR,
  input  logic                                       AXI_ARVALID,
  input  logic                                       AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]                AXI_RDATA,
  input  logic [1:0]                                 AXI_RRESP,
  input  logic                                       AXI_RVALID,
  input  logic                                       AXI_RREADY,
  input  logic                                       err_clear,
  output logic [8:0]                                 err_pulse,
  output logic [8:0]                                 err_sticky,
  output logic [ERR_CNT_WIDTH-1:0]                   err_count,
  output logic [3:0]                                 first_err,
  output logic                                       first_err_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned WW = $clog2(MAXWAIT + 2);
  localparam int unsigned TW = $clog2(RESP_MAXWAIT + 2);

  logic                        r_started;
  logic                        r_prev_arstall;
  logic [C_AXI_ADDR_WIDTH-1:0] r_prev_araddr;
  logic                        r_prev_rstall;
  logic [C_AXI_DATA_WIDTH-1:0] r_prev_rdata;
  logic [1:0]                  r_prev_rresp;
  logic [WW-1:0]               r_ar_wait;
  logic [TW-1:0]               r_resp_wait;
  logic [OW-1:0]               r_outst;
  logic [8:0]                  r_err_pulse;
  logic [8:0]                  r_err_sticky;
  logic [ERR_CNT_WIDTH-1:0]    r_err_count;
  logic [3:0]                  r_first_err;
  logic                        r_first_valid;

  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_ar_stall;
  logic          w_r_stall;
  logic          w_resp_busy;
  logic          w_any;
  logic [8:0]    w_err;
  logic [3:0]    w_first;
  logic [OW-1:0] w_outst_nxt;
  logic [WW-1:0] w_ar_wait_nxt;
  logic [TW-1:0] w_resp_wait_nxt;

  assign w_ar_hs     = AXI_ARVALID & AXI_ARREADY;
  assign w_r_hs      = AXI_RVALID & AXI_RREADY;
  assign w_ar_stall  = AXI_ARVALID & ~AXI_ARREADY;
  assign w_r_stall   = AXI_RVALID & ~AXI_RREADY;
  assign w_resp_busy = (r_outst != '0) & ~w_r_hs;
  assign w_any       = |w_err;

  // Previous-sample registers are zeroed by reset, so stability checks cannot
  // fire on the first sample after release.
  always_comb begin
    w_err    = '0;
    w_err[0] = r_prev_arstall & ~AXI_ARVALID;
    w_err[1] = r_prev_arstall & (AXI_ARADDR != r_prev_araddr);
    w_err[2] = w_ar_stall & (r_ar_wait == WW'(MAXWAIT));
    w_err[3] = r_prev_rstall & ~AXI_RVALID;
    w_err[4] = r_prev_rstall & ((AXI_RDATA != r_prev_rdata) | (AXI_RRESP != r_prev_rresp));
    w_err[5] = w_r_hs & (r_outst == '0);
    w_err[6] = w_ar_hs & ~w_r_hs & (r_outst == OW'(MAX_OUTSTANDING));
    w_err[7] = w_resp_busy & (r_resp_wait == TW'(RESP_MAXWAIT));
    w_err[8] = ~r_started & AXI_ARVALID;
  end

  always_comb begin
    w_first = '0;
    for (int unsigned i = 9; i > 0; i--) begin
      if (w_err[i-1]) w_first = 4'(i - 1);
    end
  end

  always_comb begin
    w_outst_nxt = r_outst;
    unique case ({w_ar_hs, w_r_hs})
      2'b10:   if (r_outst != OW'(MAX_OUTSTANDING)) w_outst_nxt = r_outst + 1'b1;
      2'b01:   if (r_outst != '0) w_outst_nxt = r_outst - 1'b1;
      2'b11:   if (r_outst == '0) w_outst_nxt = OW'(1);
      default: w_outst_nxt = r_outst;
    endcase
  end

  // Wait timers saturate one past their limit so each episode flags only once.
  always_comb begin
    w_ar_wait_nxt = '0;
    if (w_ar_stall) begin
      w_ar_wait_nxt = (r_ar_wait == WW'(MAXWAIT + 1)) ? r_ar_wait : r_ar_wait + 1'b1;
    end
    w_resp_wait_nxt = '0;
    if (w_resp_busy) begin
      w_resp_wait_nxt = (r_resp_wait == TW'(RESP_MAXWAIT + 1)) ? r_resp_wait : r_resp_wait + 1'b1;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_started      <= 1'b0;
      r_prev_arstall <= 1'b0;
      r_prev_araddr  <= '0;
      r_prev_rstall  <= 1'b0;
      r_prev_rdata   <= '0;
      r_prev_rresp   <= '0;
      r_ar_wait      <= '0;
      r_resp_wait    <= '0;
      r_outst        <= '0;
      r_err_pulse    <= '0;
      r_err_sticky   <= '0;
      r_err_count    <= '0;
      r_first_err    <= '0;
      r_first_valid  <= 1'b0;
    end else begin
      r_started      <= 1'b1;
      r_prev_arstall <= w_ar_stall;
      r_prev_araddr  <= AXI_ARADDR;
      r_prev_rstall  <= w_r_stall;
      r_prev_rdata   <= AXI_RDATA;
      r_prev_rresp   <= AXI_RRESP;
      r_ar_wait      <= w_ar_wait_nxt;
      r_resp_wait    <= w_resp_wait_nxt;
      r_outst        <= w_outst_nxt;
      r_err_pulse    <= w_err;
      if (err_clear) begin
        r_err_sticky  <= w_err;
        r_err_count   <= w_any ? ERR_CNT_WIDTH'(1) : '0;
        r_first_valid <= w_any;
        r_first_err   <= w_any ? w_first : '0;
      end else begin
        r_err_sticky <= r_err_sticky | w_err;
        if (w_any && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
        if (!r_first_valid && w_any) begin
          r_first_valid <= 1'b1;
          r_first_err   <= w_first;
        end
      end
    end
  end

  assign err_pulse       = r_err_pulse;
  assign err_sticky      = r_err_sticky;
  assign err_count       = r_err_count;
  assign first_err       = r_first_err;
  assign first_err_valid = r_first_valid;
  assign outstanding     = r_outst;

endmodule

// File: doc/axil_rd_monitor.md
Name: axil_rd_monitor

Overview:
- Synthesisable passive protocol monitor for a complete AXI-Lite read path: AR channel plus R channel.
- Connects in parallel with any master/slave pair and drives no bus signals.
- Converts the team's read-address assertion set into RTL error flags, and adds R-channel checks, outstanding-transaction tracking, response timeout, error counting and first-error capture.
- Usable in FPGA builds and as a formal/sim scoreboard.

Parameters:
- C_AXI_ADDR_WIDTH, 8, ARADDR width.
- C_AXI_DATA_WIDTH, 32, RDATA width.
- MAXWAIT, 5, max cycles ARREADY may lag a stalled ARVALID.
- RESP_MAXWAIT, 16, max cycles with transactions outstanding and no R handshake.
- MAX_OUTSTANDING, 4, max accepted-but-unanswered reads (>=1).
- ERR_CNT_WIDTH, 8, width of saturating error counter.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_ARESETN  in  1  asynchronous active-low reset.
- AXI_ARADDR  in  C_AXI_ADDR_WIDTH  monitored read address.
- AXI_ARVALID  in  1  monitored.
- AXI_ARREADY  in  1  monitored.
- AXI_RDATA  in  C_AXI_DATA_WIDTH  monitored.
- AXI_RRESP  in  2  monitored.
- AXI_RVALID  in  1  monitored.
- AXI_RREADY  in  1  monitored.
- err_clear  in  1  synchronous clear of sticky flags, counter and first-error capture.
- err_pulse  out  9  per-check violation, one cycle.
- err_sticky  out  9  accumulated violations since reset/clear.
- err_count  out  ERR_CNT_WIDTH  cycles with any violation, saturating.
- first_err  out  4  index of first violation since reset/clear.
- first_err_valid  out  1  first_err holds a captured index.
- outstanding  out  clog2(MAX_OUTSTANDING+1)  current outstanding reads.

Behaviour:
- Reset: AXI_ARESETN low asynchronously zeroes all outputs, all internal counters and all previous-sample registers.
- Sampling: all inputs are sampled on the rising edge of AXI_ACLK.
- Output latency: every output is registered; a violation sampled at edge N appears on err_pulse after edge N and lasts one cycle.
- Stability qualification: a stability check at edge N requires reset deasserted at both N-1 and N.
- Handshakes: ar_hs = ARVALID & ARREADY; r_hs = RVALID & RREADY.
- err bit 0: ARVALID&!ARREADY at N-1 and ARVALID low at N.
- err bit 1: ARVALID&!ARREADY at N-1 and ARADDR differs at N.
- err bit 2: ARVALID&!ARREADY for MAXWAIT+1 consecutive samples.
  - Flagged once per stall episode, on the (MAXWAIT+1)th sample.
  - The wait counter clears on ARREADY high or ARVALID low.
- err bit 3: RVALID&!RREADY at N-1 and RVALID low at N.
- err bit 4: RVALID&!RREADY at N-1 and RDATA or RRESP differs at N.
- err bit 5: r_hs while outstanding==0. This includes the case where ar_hs occurs in the same cycle, because data must not precede its address.
- err bit 6: ar_hs without r_hs while outstanding==MAX_OUTSTANDING.
- err bit 7: response timeout.
  - Timer counts samples where outstanding>0 and no r_hs; it clears on r_hs or when outstanding==0.
  - Flagged once, when the timer reaches RESP_MAXWAIT+1. Re-arms after the next r_hs.
- err bit 8: ARVALID high on the first sample after reset release.
- Outstanding counter:
  - +1 on ar_hs alone; -1 on r_hs alone; unchanged when both occur.
  - Saturates at MAX_OUTSTANDING on overflow (bit 6).
  - Floors at 0 on underflow (bit 5).
  - On simultaneous ar_hs and r_hs with 0 outstanding: bit 5 is flagged and the counter goes to 1.
- err_sticky: ORs in err_pulse every cycle.
  - err_clear zeroes it.
  - If err_clear and a new violation occur together, the sticky bits equal the new pulse.
- err_count: +1 for every cycle in which err_pulse is non-zero, regardless of how many bits are set; holds at all-ones.
  - err_clear alone sets it to 0.
  - err_clear together with a violation sets it to 1.
- first_err: when first_err_valid is 0 and err_pulse is non-zero, captures the lowest set index and sets first_err_valid; holds until err_clear.
  - err_clear together with a violation recaptures from the new pulse.
- Reset mid-transaction: outstanding, timers and previous samples are discarded, and no stability checks fire across the reset boundary.
- Monitored inputs are assumed 0/1; X checking stays in the companion SVA interface.

Test Plan:
- Single read, ARVALID+ARADDR=0x10 with ARREADY after 2 cycles, RVALID held 1 cycle later with RREADY high -> err_sticky=0, outstanding sequence 0,1,0, err_count=0.
- ARVALID stalled and ARADDR changed 0x10->0x14 while ARREADY low -> err_pulse bit 1 for exactly one cycle, first_err=1, err_count=1.
- ARREADY held low with ARVALID high for 6 samples (MAXWAIT=5) -> bit 2 pulses once on the 6th sample, not again on the 7th; err_count=1.
- 4 AR handshakes with no R, then a 5th -> outstanding=4; bit 6 set. After 17 samples without r_hs following the first AR -> bit 7 set once; err_count=2, first_err=6.
- RVALID handshake with outstanding=0 -> bit 5 and outstanding stays 0. Then assert err_clear -> err_sticky=0, err_count=0, first_err_valid=0.
- Assert AXI_ARESETN low mid-stall with outstanding=2, release with ARVALID high -> outputs 0 during reset, then bit 8 set after the first post-reset edge, and no bit 0/1 flag.
